// File: rtl/nn_pipeline_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pipeline_sequencer_if
//  Description : Stream and datapath bundle for the NN frame sequencer.
//                Carries the input sample stream (s_*), the output result
//                stream (m_*), and the drive/return pair of the fixed-latency
//                datapath (pipe_in_data / pipe_out_data).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    s_valid       sample valid               (environment -> sequencer)
//    s_ready       sequencer accepts sample   (sequencer -> environment)
//    s_data        input sample, DATA_W bits  (environment -> sequencer)
//    m_valid       result FIFO head valid     (sequencer -> environment)
//    m_ready       downstream accepts head    (environment -> sequencer)
//    m_data        result FIFO head data      (sequencer -> environment)
//    pipe_in_data  registered datapath input  (sequencer -> datapath)
//    pipe_out_data datapath final output      (datapath -> sequencer)
//  Modports
//    slave  : the sequencer side
//    master : the surrounding wrapper / datapath side
// ============================================================================
interface nn_pipeline_sequencer_if #(
  parameter int DATA_W = 8
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] pipe_in_data;
  logic [DATA_W-1:0] pipe_out_data;

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    input  pipe_out_data,
    output s_ready,
    output m_valid,
    output m_data,
    output pipe_in_data
  );

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    output pipe_out_data,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  pipe_in_data
  );

endinterface
`default_nettype wire

// File: rtl/nn_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pipeline_sequencer
//  Description : Frame sequencer for a free-running, fixed-latency NN
//                datapath. Accepts FRAME_LEN samples per start command,
//                drives them one per cycle into the datapath, tracks valid
//                datapath outputs with a token shift register and captures
//                them into an output FIFO. Input acceptance is credit based
//                (in-flight tokens + FIFO occupancy), so back-pressure on the
//                output stream can never lose a result.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   single clock, rising edge
//    reset  in   asynchronous, active-high
//    start  in   begins a frame when idle (level sampled)
//    abort  in   returns to idle and discards all data (level sampled)
//    bus    --   stream / datapath bundle, slave modport
//    busy   out  high while running or draining
//    done   out  one-cycle pulse when a frame has fully drained
//    state  out  IDLE=0, RUN=1, DRAIN=2, DONE=3
// ============================================================================
module nn_pipeline_sequencer #(
  parameter int DATA_W     = 8,
  parameter int LATENCY    = 7,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  nn_pipeline_sequencer_if.slave        bus,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
  localparam int c_FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_FRM_CNT_W  = $clog2(FRAME_LEN + 1);
  // Wide enough for (tokens in flight) + (FIFO occupancy) at their maxima.
  localparam int c_SUM_W      = $clog2(FIFO_DEPTH + LATENCY + 1);

  localparam logic [c_FRM_CNT_W-1:0] c_FRAME     = c_FRM_CNT_W'(FRAME_LEN);
  localparam logic [c_FRM_CNT_W-1:0] c_FRAME_M1  = c_FRM_CNT_W'(FRAME_LEN - 1);
  localparam logic [c_SUM_W-1:0]     c_DEPTH_SUM = c_SUM_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [LATENCY-1:0]      r_tokens;
  logic [c_FRM_CNT_W-1:0]  r_in_cnt;
  logic [c_FRM_CNT_W-1:0]  r_out_cnt;
  logic [DATA_W-1:0]       r_pipe_in;

  logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_FIFO_CNT_W-1:0] r_fifo_cnt;

  logic                    w_start_ok;
  logic                    w_clear;
  logic [c_SUM_W-1:0]      w_credit_used;
  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_fifo_empty;
  logic                    w_m_valid;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drain_done;

  // Number of samples currently travelling through the datapath.
  function automatic logic [c_SUM_W-1:0] f_popcount(input logic [LATENCY-1:0] v);
    logic [c_SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < LATENCY; i++) begin
      n = n + c_SUM_W'(v[i]);
    end
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and credit logic
  // --------------------------------------------------------------------------
  assign w_start_ok = (r_state == c_IDLE) && start && !abort;

  // Frame start and abort both flush tokens, counters and the FIFO.
  assign w_clear    = abort || w_start_ok;

  // Every in-flight token already owns a FIFO slot; a new sample is admitted
  // only while at least one slot is unclaimed. This keeps the FIFO from ever
  // overflowing regardless of m_ready, and keeps m_ready out of the s_ready
  // combinational cone.
  assign w_credit_used = f_popcount(r_tokens) + c_SUM_W'(r_fifo_cnt);

  assign w_s_ready = (r_state == c_RUN)
                  && (r_in_cnt < c_FRAME)
                  && (w_credit_used < c_DEPTH_SUM);

  assign w_accept     = bus.s_valid && w_s_ready;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_m_valid    = !w_fifo_empty;
  assign w_pop        = w_m_valid && bus.m_ready;

  // The oldest token position lines up with the datapath result belonging
  // to the sample accepted LATENCY edges earlier.
  assign w_push = r_tokens[LATENCY-1] && (r_state != c_IDLE);

  assign w_drain_done = (r_tokens == '0) && w_fifo_empty && (r_out_cnt == c_FRAME);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            w_state_nxt = c_RUN;
          end
        end
        c_RUN: begin
          if (w_accept && (r_in_cnt == c_FRAME_M1)) begin
            w_state_nxt = c_DRAIN;
          end
        end
        c_DRAIN: begin
          if (w_drain_done) begin
            w_state_nxt = c_DONE;
          end
        end
        c_DONE: begin
          w_state_nxt = c_IDLE;
        end
        default: begin
          w_state_nxt = c_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_tokens  <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_pipe_in <= '0;
    end else begin
      r_state <= w_state_nxt;

      // The datapath input holds its last sample when nothing is accepted.
      if (w_accept) begin
        r_pipe_in <= bus.s_data;
      end

      if (w_clear) begin
        r_tokens  <= '0;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (r_state != c_IDLE) begin
          r_tokens <= (r_tokens << 1) | LATENCY'(w_accept);
        end
        // in_cnt cannot pass FRAME_LEN because s_ready is gated on it.
        if (w_accept) begin
          r_in_cnt <= r_in_cnt + c_FRM_CNT_W'(1);
        end
        if (w_pop && (r_out_cnt != c_FRAME)) begin
          r_out_cnt <= r_out_cnt + c_FRM_CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_FIFO_CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_FIFO_CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wr_ptr] <= bus.pipe_out_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.s_ready      = w_s_ready;
  assign bus.m_valid      = w_m_valid;
  // Forced to zero while empty so m_data reads 0 straight out of reset.
  assign bus.m_data       = w_m_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.pipe_in_data = r_pipe_in;

  assign busy  = (r_state == c_RUN) || (r_state == c_DRAIN);
  assign done  = (r_state == c_DONE);
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_nn_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nn_pipeline_sequencer
//  Description : Directed and randomised checks for nn_pipeline_sequencer.
//                Contains a datapath stand-in (pipe_in_data + 8'h60, aligned
//                so the result is present at the push edge LATENCY edges
//                after the accept) and an in-order scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nn_pipeline_sequencer;

  localparam int DATA_W     = 8;
  localparam int LATENCY    = 7;
  localparam int FIFO_DEPTH = 16;
  localparam int FRAME_LEN  = 16;
  localparam int DP_STAGES  = LATENCY - 1;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] state;

  nn_pipeline_sequencer_if #(.DATA_W(DATA_W)) bus ();

  nn_pipeline_sequencer #(
    .DATA_W    (DATA_W),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: pipe_in_data changes at the accept edge and the result
  // must be present just before the push edge LATENCY edges later.
  logic [DATA_W-1:0] r_dp [DP_STAGES];
  always @(posedge clk) begin
    r_dp[0] <= bus.pipe_in_data + 8'h60;
    for (int i = 1; i < DP_STAGES; i++) r_dp[i] <= r_dp[i-1];
  end
  assign bus.pipe_out_data = r_dp[DP_STAGES-1];

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int acc_n    = 0;
  int pop_n    = 0;
  int done_n   = 0;
  int acc_base, pop_base, done_base;
  int first_acc_cyc, first_mv_cyc, last_pop_cyc, done_cyc;
  int t0;
  logic [DATA_W-1:0] exp_q [$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_mdata = '0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic frame_mark();
    acc_base      = acc_n;
    pop_base      = pop_n;
    done_base     = done_n;
    first_acc_cyc = -1;
    first_mv_cyc  = -1;
    last_pop_cyc  = -1;
    done_cyc      = -1;
  endtask

  // Called just after a falling edge with inputs already driven. Observes the
  // cycle, updates the scoreboard, then advances to the next falling edge.
  task automatic step();
    #1;
    if (bus.m_valid && first_mv_cyc < 0) first_mv_cyc = cyc_n;
    if (done) begin
      done_n++;
      done_cyc = cyc_n;
    end
    if (prev_stall) begin
      chk_eq("hold_valid", bus.m_valid, 1);
      chk_eq("hold_data", bus.m_data, prev_mdata);
    end
    if (bus.m_valid && bus.m_ready) begin
      chk_eq("pop_has_expect", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk_eq("pop_data", bus.m_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      pop_n++;
      last_pop_cyc = cyc_n;
    end
    if (bus.s_valid && bus.s_ready) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc_n;
      exp_q.push_back(bus.s_data + 8'h60);
      acc_n++;
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_mdata = bus.m_data;
    if (abort) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end
    chk_eq("credit_bound", exp_q.size() <= FIFO_DEPTH, 1);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n;
    n = 0;
    while (done_n == done_base && n < budget) begin
      if (rnd) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.m_ready = 1'($urandom_range(0, 1));
        bus.s_data  = 8'($urandom);
      end else begin
        bus.s_data  = 8'(acc_n - acc_base);
      end
      step();
      n++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start       = 1'($urandom_range(0, 1));
      abort       = 1'($urandom_range(0, 1));
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
    end
    #1;
    chk_eq("rst_state", state, 0);
    chk_eq("rst_s_ready", bus.s_ready, 0);
    chk_eq("rst_m_valid", bus.m_valid, 0);
    chk_eq("rst_m_data", bus.m_data, 0);
    chk_eq("rst_pipe_in", bus.pipe_in_data, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_eq("nostart_s_ready", bus.s_ready, 0);
    chk_eq("nostart_state", state, 0);

    // Nominal frame, s_data 0x00..0x0F, m_ready=1
    frame_mark();
    bus.s_valid = 1'b1; bus.m_ready = 1'b1; bus.s_data = '0; start = 1'b1;
    t0 = cyc_n;
    step();
    start = 1'b0;
    run_until_done(80, 1'b0);
    chk_eq("nom_accepts", acc_n - acc_base, FRAME_LEN);
    chk_eq("nom_pops", pop_n - pop_base, FRAME_LEN);
    chk_eq("nom_first_acc", first_acc_cyc - t0, 1);
    // Valid rises at the 7th edge after the accept edge, seen one cycle on.
    chk_eq("nom_first_mvalid", first_mv_cyc - first_acc_cyc, LATENCY + 1);
    chk_eq("nom_last_pop", last_pop_cyc - t0, FRAME_LEN + LATENCY + 1);
    chk_eq("nom_done_cyc", done_cyc - t0, FRAME_LEN + LATENCY + 3);
    chk_eq("nom_done_cnt", done_n - done_base, 1);
    chk_eq("nom_idle", state, 0);
    chk_eq("nom_done_low", done, 0);
    chk_eq("nom_sb_empty", exp_q.size(), 0);

    // Back-pressure: m_ready=0 fills the frame, then drain
    frame_mark();
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.s_data = 8'hA0 + 8'(acc_n - acc_base);
      step();
    end
    chk_eq("bp_accepts", acc_n - acc_base, FRAME_LEN);
    chk_eq("bp_s_ready", bus.s_ready, 0);
    chk_eq("bp_state", state, 2);
    chk_eq("bp_m_valid", bus.m_valid, 1);
    chk_eq("bp_busy", busy, 1);
    bus.m_ready = 1'b1;
    run_until_done(60, 1'b0);
    chk_eq("bp_pops", pop_n - pop_base, FRAME_LEN);
    chk_eq("bp_done_cnt", done_n - done_base, 1);
    chk_eq("bp_sb_empty", exp_q.size(), 0);

    // Abort after 5 accepts: 2 in the FIFO, 3 still in flight
    frame_mark();
    bus.m_ready = 1'b0; bus.s_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = (i < 2) || (i >= 7);
      bus.s_data  = 8'h10 + 8'(i);
      step();
    end
    chk_eq("ab_accepts", acc_n - acc_base, 5);
    chk_eq("ab_m_valid_pre", bus.m_valid, 1);
    bus.s_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk_eq("ab_state", state, 0);
    chk_eq("ab_m_valid", bus.m_valid, 0);
    chk_eq("ab_busy", busy, 0);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_eq("ab_no_stale", bus.m_valid, 0);
    end
    chk_eq("ab_no_done", done_n - done_base, 0);
    frame_mark();
    bus.s_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(80, 1'b0);
    chk_eq("ab_clean_pops", pop_n - pop_base, FRAME_LEN);
    chk_eq("ab_clean_done", done_n - done_base, 1);
    chk_eq("ab_clean_sb", exp_q.size(), 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_eq("sa_state", state, 0);
    chk_eq("sa_busy", busy, 0);

    // start pulsed during RUN is ignored
    frame_mark();
    bus.s_valid = 1'b1; bus.m_ready = 1'b1; start = 1'b1;
    t0 = cyc_n;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 8'(acc_n - acc_base);
      step();
    end
    start = 1'b1;
    bus.s_data = 8'(acc_n - acc_base);
    step();
    start = 1'b0;
    run_until_done(80, 1'b0);
    chk_eq("sr_accepts", acc_n - acc_base, FRAME_LEN);
    chk_eq("sr_pops", pop_n - pop_base, FRAME_LEN);
    chk_eq("sr_done_cyc", done_cyc - t0, FRAME_LEN + LATENCY + 3);

    // Asynchronous reset in DRAIN
    frame_mark();
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && state != 2'd2; i++) begin
      bus.s_data = 8'(acc_n - acc_base);
      step();
    end
    chk_eq("ar_in_drain", state, 2);
    #2 reset = 1'b1;
    #1;
    chk_eq("ar_state", state, 0);
    chk_eq("ar_s_ready", bus.s_ready, 0);
    chk_eq("ar_m_valid", bus.m_valid, 0);
    chk_eq("ar_m_data", bus.m_data, 0);
    chk_eq("ar_pipe_in", bus.pipe_in_data, 0);
    chk_eq("ar_busy", busy, 0);
    chk_eq("ar_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_eq("ar_stay_idle", state, 0);
    chk_eq("ar_no_ready", bus.s_ready, 0);

    // Random s_valid / m_ready, 1000 frames
    for (int f = 0; f < 1000; f++) begin
      frame_mark();
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
      start = 1'b1;
      step();
      start = 1'b0;
      run_until_done(400, 1'b1);
      chk_eq("rnd_done_cnt", done_n - done_base, 1);
      chk_eq("rnd_pops", pop_n - pop_base, FRAME_LEN);
      chk_eq("rnd_sb_empty", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
